// File: rtl/control_setare_pkg.sv
// Shared state encoding, field codes and limits for the time-setting controller.
package pkg_ceas;

    typedef enum logic [1:0] {
        REPAUS     = 2'd0,
        SET_ORE    = 2'd1,
        SET_MINUTE = 2'd2,
        SCRIE      = 2'd3
    } stare_t;

    localparam logic [4:0] ORE_MAX    = 5'd23;
    localparam logic [5:0] MINUTE_MAX = 6'd59;

    localparam logic [1:0] CAMP_NIMIC  = 2'b00;
    localparam logic [1:0] CAMP_ORE    = 2'b01;
    localparam logic [1:0] CAMP_MINUTE = 2'b10;

    // Hours step with wrap 23 -> 0.
    function automatic logic [4:0] urm_ore(input logic [4:0] v);
        return (v == ORE_MAX) ? 5'd0 : v + 5'd1;
    endfunction

    // Minutes step with wrap 59 -> 0.
    function automatic logic [5:0] urm_minute(input logic [5:0] v);
        return (v == MINUTE_MAX) ? 6'd0 : v + 6'd1;
    endfunction

    // Out-of-range live values are captured as 0.
    function automatic logic [4:0] limit_ore(input logic [4:0] v);
        return (v > ORE_MAX) ? 5'd0 : v;
    endfunction

    function automatic logic [5:0] limit_minute(input logic [5:0] v);
        return (v > MINUTE_MAX) ? 6'd0 : v;
    endfunction

endpackage

// File: rtl/detector_front.sv
// Rising-edge detector: one-cycle pulse when the input goes 0 -> 1.
module detector_front (
    input  logic clock,
    input  logic reset,
    input  logic semnal,
    output logic puls
);

    logic semnal_q;
    logic semnal_d;

    // Next value of the history register is simply the current level.
    always_comb begin
        semnal_d = semnal;
    end

    // History register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) semnal_q <= 1'b0;
        else       semnal_q <= semnal_d;
    end

    // Pulse is combinational so the action lands on the same edge.
    always_comb begin
        puls = semnal & ~semnal_q;
    end

endmodule

// File: rtl/control_setare.sv
// Time-setting controller: snapshot live time, edit hours then minutes,
// commit with a one-cycle load pulse, abandon on inactivity.
module control_setare
    import pkg_ceas::*;
#(
    parameter int unsigned TIMEOUT_CICLI = 30000000,
    parameter int unsigned CLIPIRE_CICLI = 12500000,
    parameter int unsigned LATIME_CNT    = 25
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       buton_mod,
    input  logic       buton_plus,
    input  logic [4:0] ore,
    input  logic [5:0] minute,
    output logic [4:0] ore_setare,
    output logic [5:0] minute_setare,
    output logic       semnal_setare,
    output logic       incarca,
    output logic [1:0] camp_activ,
    output logic       clipire
);

    localparam logic [LATIME_CNT-1:0] TIMEOUT_ULTIM = LATIME_CNT'(TIMEOUT_CICLI - 1);
    localparam logic [LATIME_CNT-1:0] CLIPIRE_ULTIM = LATIME_CNT'(CLIPIRE_CICLI - 1);
    localparam logic [LATIME_CNT-1:0] UNU           = LATIME_CNT'(1);

    logic apasare_mod;
    logic apasare_plus;

    stare_t                stare_q, stare_d;
    logic [4:0]            ore_setare_q, ore_setare_d;
    logic [5:0]            minute_setare_q, minute_setare_d;
    logic                  semnal_setare_q, semnal_setare_d;
    logic                  incarca_q, incarca_d;
    logic [1:0]            camp_activ_q, camp_activ_d;
    logic                  clipire_q, clipire_d;
    logic [LATIME_CNT-1:0] cnt_timeout_q, cnt_timeout_d;
    logic [LATIME_CNT-1:0] cnt_clipire_q, cnt_clipire_d;

    detector_front u_front_mod (
        .clock  (clock),
        .reset  (reset),
        .semnal (buton_mod),
        .puls   (apasare_mod)
    );

    detector_front u_front_plus (
        .clock  (clock),
        .reset  (reset),
        .semnal (buton_plus),
        .puls   (apasare_plus)
    );

    // Next-state, value edits, timeout/blink counters and registered outputs.
    always_comb begin
        stare_d         = stare_q;
        ore_setare_d    = ore_setare_q;
        minute_setare_d = minute_setare_q;
        cnt_timeout_d   = '0;
        cnt_clipire_d   = '0;
        clipire_d       = 1'b0;

        unique case (stare_q)
            REPAUS: begin
                if (apasare_mod) begin
                    stare_d         = SET_ORE;
                    ore_setare_d    = limit_ore(ore);
                    minute_setare_d = limit_minute(minute);
                end
            end
            SET_ORE, SET_MINUTE: begin
                // Priority: mod, then plus, then timeout, then idle counting.
                if (apasare_mod) begin
                    stare_d = (stare_q == SET_ORE) ? SET_MINUTE : SCRIE;
                end else if (apasare_plus) begin
                    if (stare_q == SET_ORE) ore_setare_d    = urm_ore(ore_setare_q);
                    else                    minute_setare_d = urm_minute(minute_setare_q);
                end else if (cnt_timeout_q == TIMEOUT_ULTIM) begin
                    stare_d = REPAUS;
                end else begin
                    cnt_timeout_d = cnt_timeout_q + UNU;
                    clipire_d     = clipire_q;
                    if (cnt_clipire_q == CLIPIRE_ULTIM) begin
                        clipire_d = ~clipire_q;
                    end else begin
                        cnt_clipire_d = cnt_clipire_q + UNU;
                    end
                end
            end
            SCRIE: begin
                stare_d = REPAUS;
            end
            default: begin
                stare_d = REPAUS;
            end
        endcase

        semnal_setare_d = (stare_d != REPAUS);
        incarca_d       = (stare_d == SCRIE);
        unique case (stare_d)
            SET_ORE:    camp_activ_d = CAMP_ORE;
            SET_MINUTE: camp_activ_d = CAMP_MINUTE;
            default:    camp_activ_d = CAMP_NIMIC;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            stare_q         <= REPAUS;
            ore_setare_q    <= '0;
            minute_setare_q <= '0;
            semnal_setare_q <= 1'b0;
            incarca_q       <= 1'b0;
            camp_activ_q    <= CAMP_NIMIC;
            clipire_q       <= 1'b0;
            cnt_timeout_q   <= '0;
            cnt_clipire_q   <= '0;
        end else begin
            stare_q         <= stare_d;
            ore_setare_q    <= ore_setare_d;
            minute_setare_q <= minute_setare_d;
            semnal_setare_q <= semnal_setare_d;
            incarca_q       <= incarca_d;
            camp_activ_q    <= camp_activ_d;
            clipire_q       <= clipire_d;
            cnt_timeout_q   <= cnt_timeout_d;
            cnt_clipire_q   <= cnt_clipire_d;
        end
    end

    // Drive ports straight from the output registers.
    always_comb begin
        ore_setare    = ore_setare_q;
        minute_setare = minute_setare_q;
        semnal_setare = semnal_setare_q;
        incarca       = incarca_q;
        camp_activ    = camp_activ_q;
        clipire       = clipire_q;
    end

endmodule
